// File: rtl/control_pkg.sv
// ---------------------------------------------------------------------------
// control_pkg
// Shared encodings for the MIPS decode-stage control unit. It holds the
// opcode and funct field values, the main-decoder ALU class (ALUOp), the
// 4-bit ALU control codes, and the bundle of main-decoder control bits.
// ---------------------------------------------------------------------------
package control_pkg;

    // Opcode field, instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // Funct field, instruction[5:0], for R-type
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU class chosen by the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Main-decoder output bundle
    typedef struct packed {
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic       branch;
        logic       mem_write;
        logic       mem_to_reg;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational ALU-control decoder. It maps the main decoder's ALU class,
// together with funct (R-type) or opcode (immediate logic), to a 4-bit
// ALU operation.
// Ports:
//   ALUOp      in  2  ALU class from the main decoder
//   funct      in  6  instruction[5:0]
//   opcode     in  6  instruction[31:26]
//   ALUControl out 4  ALU operation select
// ---------------------------------------------------------------------------
module alu_decoder
    import control_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] funct,
    input  logic [5:0] opcode,
    output logic [3:0] ALUControl
);

    always_comb begin
        // NOTE: assigning a default before the case means every path drives
        // ALUControl, so no latch is inferred.
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  ALUControl = ALU_ADD;
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    FN_NOR:  ALUControl = ALU_NOR;
                    FN_SLT:  ALUControl = ALU_SLT;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            ALUOP_IMM: begin
                case (opcode)
                    OP_ANDI: ALUControl = ALU_AND;
                    OP_ORI:  ALUControl = ALU_OR;
                    OP_SLTI: ALUControl = ALU_SLT;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Decode-stage control unit for the 5-stage MIPS pipeline. It decodes the
// opcode and funct fields and registers the resulting control signals. The
// outputs are valid one cycle after the instruction is presented.
// Ports:
//   clk          in  1   rising-edge clock
//   rst_n        in  1   asynchronous active-low reset, clears all outputs
//   instruction  in  32  instruction word in D stage
//   regWriteD    out 1   write register file
//   memToRegD    out 1   writeback selects memory data
//   memWriteD    out 1   write data memory
//   ALUControlD  out 4   ALU operation select
//   ALUSrcD      out 1   ALU operand B is the sign-extended immediate
//   regDstD      out 1   destination is rd (1) or rt (0)
//   branchD      out 1   instruction is beq
//   ALUOp        out 2   main-decoder ALU class
// ---------------------------------------------------------------------------
module control_unit
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    output logic        regWriteD,
    output logic        memToRegD,
    output logic        memWriteD,
    output logic [3:0]  ALUControlD,
    output logic        ALUSrcD,
    output logic        regDstD,
    output logic        branchD,
    output logic [1:0]  ALUOp
);

    logic [5:0] opcode;
    logic [5:0] funct;
    ctrl_t      main_ctrl;
    logic [3:0] alu_control;
    logic       unused_fields;

    assign opcode = instruction[31:26];
    assign funct  = instruction[5:0];

    // Register fields and the immediate do not affect control.
    assign unused_fields = ^instruction[25:6];

    // Main decoder. Unknown opcodes fall through to all-zero (NOP).
    always_comb begin
        main_ctrl = '0;
        case (opcode)
            OP_RTYPE: main_ctrl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT};
            OP_LW:    main_ctrl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ALUOP_ADD};
            OP_SW:    main_ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ALUOP_ADD};
            OP_BEQ:   main_ctrl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_SUB};
            OP_ADDI:  main_ctrl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_ADD};
            OP_ANDI,
            OP_ORI,
            OP_SLTI:  main_ctrl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_IMM};
            default:  main_ctrl = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (main_ctrl.alu_op),
        .funct      (funct),
        .opcode     (opcode),
        .ALUControl (alu_control)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: registered state uses non-blocking assignments so that all
            // flops update together at the edge, independent of statement order.
            regWriteD   <= 1'b0;
            memToRegD   <= 1'b0;
            memWriteD   <= 1'b0;
            ALUControlD <= 4'b0000;
            ALUSrcD     <= 1'b0;
            regDstD     <= 1'b0;
            branchD     <= 1'b0;
            ALUOp       <= 2'b00;
        end else begin
            regWriteD   <= main_ctrl.reg_write;
            memToRegD   <= main_ctrl.mem_to_reg;
            memWriteD   <= main_ctrl.mem_write;
            ALUControlD <= alu_control;
            ALUSrcD     <= main_ctrl.alu_src;
            regDstD     <= main_ctrl.reg_dst;
            branchD     <= main_ctrl.branch;
            ALUOp       <= main_ctrl.alu_op;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Self-checking bench for control_unit. The expected outputs come from a
// table-driven model of the instruction set: each instruction has a row of
// control bits and an ALU operation name, and the name is then mapped to
// its code. Observed bundle order:
// {regWrite, memToReg, memWrite, ALUControl[3:0], ALUSrc, regDst, branch, ALUOp[1:0]}
// ---------------------------------------------------------------------------
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic        regWriteD, memToRegD, memWriteD, ALUSrcD, regDstD, branchD;
    logic [3:0]  ALUControlD;
    logic [1:0]  ALUOp;

    logic [11:0] obs;
    logic [11:0] prev_exp;
    int          total = 0;
    int          bad   = 0;

    control_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .regWriteD   (regWriteD),
        .memToRegD   (memToRegD),
        .memWriteD   (memWriteD),
        .ALUControlD (ALUControlD),
        .ALUSrcD     (ALUSrcD),
        .regDstD     (regDstD),
        .branchD     (branchD),
        .ALUOp       (ALUOp)
    );

    always #5 clk = ~clk;

    assign obs = {regWriteD, memToRegD, memWriteD, ALUControlD,
                  ALUSrcD, regDstD, branchD, ALUOp};

    // Instruction table: opcode, mnemonic, regWrite, regDst, ALUSrc,
    // branch, memWrite, memToReg, ALU class.
    logic [5:0] op_tab   [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                 6'b001000, 6'b001100, 6'b001101, 6'b001010};
    string      name_tab [8] = '{"rtype", "lw", "sw", "beq",
                                 "addi", "andi", "ori", "slti"};
    logic [5:0] bits_tab [8] = '{6'b110000, 6'b101001, 6'b001010, 6'b000100,
                                 6'b101000, 6'b101000, 6'b101000, 6'b101000};
    logic [1:0] cls_tab  [8] = '{2'b10, 2'b00, 2'b00, 2'b01,
                                 2'b00, 2'b11, 2'b11, 2'b11};

    // R-type funct table and the operation each one selects
    logic [5:0] fn_tab    [6] = '{6'b100000, 6'b100010, 6'b100100,
                                  6'b100101, 6'b100111, 6'b101010};
    string      fn_op_tab [6] = '{"ADD", "SUB", "AND", "OR", "NOR", "SLT"};

    function automatic logic [3:0] alu_code(string op);
        case (op)
            "AND":   return 4'b0000;
            "OR":    return 4'b0001;
            "SUB":   return 4'b0110;
            "SLT":   return 4'b0111;
            "NOR":   return 4'b1100;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic [11:0] model(logic [31:0] ins);
        logic [5:0] op   = ins[31:26];
        logic [5:0] fn   = ins[5:0];
        string      mn   = "nop";
        logic [5:0] bits = 6'b000000;
        logic [1:0] cls  = 2'b00;
        string      aop  = "ADD";
        for (int i = 0; i < 8; i++)
            if (op_tab[i] == op) begin
                mn   = name_tab[i];
                bits = bits_tab[i];
                cls  = cls_tab[i];
            end
        if (mn == "rtype") begin
            for (int i = 0; i < 6; i++)
                if (fn_tab[i] == fn) aop = fn_op_tab[i];
        end else if (mn == "beq")  aop = "SUB";
        else if (mn == "andi")     aop = "AND";
        else if (mn == "ori")      aop = "OR";
        else if (mn == "slti")     aop = "SLT";
        // bits: rw rd src br mw m2r
        return {bits[5], bits[0], bits[1], alu_code(aop),
                bits[3], bits[4], bits[2], cls};
    endfunction

    task automatic check(string tag, logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Present an instruction mid-cycle, confirm the outputs hold until the
    // edge, then confirm the decoded value one edge later.
    task automatic step(string tag, logic [31:0] ins);
        @(negedge clk);
        instruction = ins;
        #1 check({tag, "_hold"}, prev_exp);
        @(posedge clk);
        #1;
        prev_exp = model(ins);
        check(tag, prev_exp);
    endtask

    initial begin
        logic [31:0] ins;
        rst_n       = 1'b1;
        instruction = 32'h0043_0820;
        prev_exp    = '0;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1 check("reset_async", 12'h000);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", 12'h000);

        @(negedge clk);
        rst_n = 1'b1;
        #1 check("release_no_edge", 12'h000);
        @(posedge clk);
        #1;
        prev_exp = model(instruction);
        check("first_edge_add", prev_exp);
        check("add_literal", 12'b1_0_0_0010_0_1_0_10);

        // R-type funct sweep, out-of-table funct, sll nop
        step("sub", 32'h0043_0822);
        check("sub_literal", 12'b1_0_0_0110_0_1_0_10);
        step("and", 32'h0043_0824);
        step("or",  32'h0043_0825);
        step("nor", 32'h0043_0827);
        check("nor_literal", 12'b1_0_0_1100_0_1_0_10);
        step("slt", 32'h0043_082A);
        step("fn3f", 32'h0043_083F);
        step("sll_nop", 32'h0000_0000);

        // Memory, branch, immediates
        step("lw", 32'h8C41_0004);
        check("lw_literal", 12'b1_1_0_0010_1_0_0_00);
        step("sw", 32'h AC41_0004);
        check("sw_literal", 12'b0_0_1_0010_1_0_0_00);
        step("beq", 32'h1043_0003);
        check("beq_literal", 12'b0_0_0_0110_0_0_1_01);
        step("addi", 32'h2041_000F);
        step("andi", 32'h3041_000F);
        step("ori",  32'h3441_000F);
        check("ori_literal", 12'b1_0_0_0001_1_0_0_11);
        step("slti", 32'h2841_000F);
        check("slti_literal", 12'b1_0_0_0111_1_0_0_11);
        step("op3f", 32'hFC43_0820);
        check("op3f_literal", 12'b0_0_0_0010_0_0_0_00);

        // Reset mid-stream clears without an edge; first edge after
        // release decodes the current instruction.
        step("pre_reset_lw", 32'h8C41_0004);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("mid_reset", 12'h000);
        @(posedge clk);
        #1 check("mid_reset_hold", 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        prev_exp = model(instruction);
        check("post_reset", prev_exp);

        // Randomized back-to-back stream
        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) < 8)
                ins[31:26] = op_tab[$urandom_range(0, 7)];
            if (ins[31:26] == 6'b000000 && $urandom_range(0, 3) != 0)
                ins[5:0] = fn_tab[$urandom_range(0, 5)];
            step("rand", ins);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Decode-stage control unit for the 32-bit MIPS 5-stage pipelined processor.
- Decodes the fetched instruction's opcode [31:26] and funct [5:0] into datapath control signals for the D stage.
- All outputs are registered: they are valid one cycle after the instruction is presented and feed the D/E pipeline logic.

Parameters:
- None. Opcode, funct and ALU-control encodings are fixed constants in the shared package.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- instruction  input  32  instruction word in D stage
- regWriteD  output  1  write register file
- memToRegD  output  1  writeback selects memory data
- memWriteD  output  1  write data memory
- ALUControlD  output  4  ALU operation select
- ALUSrcD  output  1  ALU operand B = sign-extended immediate
- regDstD  output  1  destination is rd (1) or rt (0)
- branchD  output  1  instruction is beq
- ALUOp  output  2  main-decoder ALU class (00 add, 01 sub, 10 funct, 11 immediate-logic)

Behaviour:
- Reset: rst_n low asynchronously clears every output to 0, including ALUOp=00 and ALUControlD=0000. Outputs hold 0 until the first rising edge after rst_n deasserts.
- Latency: combinational decode of instruction, captured into output registers on each rising clk edge.
  - Outputs change only on clk edges or on reset.
  - Latency is 1 cycle; the instruction may change every cycle.
- Main decode, listed as op: regWrite, regDst, ALUSrc, branch, memWrite, memToReg, ALUOp.
  - R-type 000000: 1, 1, 0, 0, 0, 0, 10
  - lw 100011: 1, 0, 1, 0, 0, 1, 00
  - sw 101011: 0, 0, 1, 0, 1, 0, 00
  - beq 000100: 0, 0, 0, 1, 0, 0, 01
  - addi 001000: 1, 0, 1, 0, 0, 0, 00
  - andi 001100: 1, 0, 1, 0, 0, 0, 11
  - ori 001101: 1, 0, 1, 0, 0, 0, 11
  - slti 001010: 1, 0, 1, 0, 0, 0, 11
  - Any other opcode: all controls 0, ALUOp=00 (behaves as a NOP; no register or memory writes).
- ALU decode (ALUControlD): AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
  - ALUOp=00 gives ADD; ALUOp=01 gives SUB.
  - ALUOp=10 decodes funct:
    - 100000 → ADD, 100010 → SUB, 100100 → AND
    - 100101 → OR, 100111 → NOR, 101010 → SLT
    - any other funct → ADD
  - ALUOp=11 decodes opcode: andi → AND, ori → OR, slti → SLT; otherwise ADD.
- Instruction 0x00000000 (sll $0 nop): R-type with funct 000000 gives regWrite=1, regDst=1, ALUControl=ADD. This is harmless because the destination is $0.
- Reset asserted mid-stream: outputs clear immediately. After release, the first edge captures the decode of the current instruction.
- No handshake and no stall/flush input; hazard handling is external.

Decomposition:
- Package control_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI)
  - funct constants
  - ALUOp class constants
  - 4-bit ALU control constants
- One combinational sub-module, alu_decoder (inputs: ALUOp, funct, opcode; output: ALUControl), instantiated by control_unit.
- The main decoder and output registers stay in control_unit.

Test Plan:
- Reset: rst_n=0 with any instruction → all outputs 0 immediately, with no clk edge required. Release, then one edge → outputs reflect the instruction.
- add $1,$2,$3 (0x00430820), one edge → regWriteD=1, regDstD=1, ALUSrcD=0, memToRegD=0, memWriteD=0, branchD=0, ALUOp=10, ALUControlD=0010. Outputs unchanged before the edge.
- R-type funct sweep: sub, and, or, nor, slt (e.g. 0x00430822, …24, …25, …27, …2A) → ALUControlD 0110, 0000, 0001, 1100, 0111 respectively, each one cycle later. Funct 111111 → 0010.
- lw 0x8C410004 → regWrite=1, ALUSrc=1, memToReg=1, regDst=0, ALUOp=00, ALUCtrl=0010. sw 0xAC410004 → memWrite=1, regWrite=0, ALUSrc=1.
- beq 0x10430003 → branchD=1, regWrite=0, ALUOp=01, ALUCtrl=0110. andi/ori/slti (0x3041000F, 0x3441000F, 0x2841000F) → ALUOp=11, ALUCtrl 0000, 0001, 0111, ALUSrc=1.
- Back-to-back instructions on consecutive edges each appear one cycle later. Unknown opcode 111111 → all controls 0. Assert rst_n mid-sequence → immediate clear.
